// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the execute-stage hazard controller: writeback
// sources, forwarding selects, FSM states and control-word field offsets.
package ex_hazard_ctrl_pkg;

    // Writeback source carried in the ID/EX control word.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    // Operand mux select for the EX-stage A/B operands.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Sequencing FSM.
    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    // Width of the multi-cycle down-counter (holds up to MC_LATENCY-2 = 14).
    localparam int MC_CNT_W = 4;

    // 14-bit EX control word layout.
    localparam int EX_CTRL_W        = 14;
    localparam int EX_RF_WB_BIT     = 0;
    localparam int EX_WB_SRC_LSB    = 1;   // 2 bits
    localparam int EX_MEM_WE_BIT    = 3;
    localparam int EX_MEM_RE_BIT    = 4;
    localparam int EX_BRANCH_BIT    = 5;
    localparam int EX_PC_SRC_BIT    = 6;
    localparam int EX_ALU_OP_LSB    = 7;   // 4 bits
    localparam int EX_ALU_SRC_BIT   = 11;
    localparam int EX_MC_OP_BIT     = 12;
    localparam int EX_JALR_BIT      = 13;

    // 23-bit decode control word layout; the low bits carry the EX word.
    localparam int DEC_CTRL_W       = 23;
    localparam int DEC_EX_LSB       = 0;   // EX_CTRL_W bits
    localparam int DEC_USE_RS1_BIT  = 14;
    localparam int DEC_USE_RS2_BIT  = 15;
    localparam int DEC_IMM_SEL_LSB  = 16;  // 3 bits
    localparam int DEC_CSR_OP_LSB   = 19;  // 2 bits
    localparam int DEC_ILLEGAL_BIT  = 21;
    localparam int DEC_FENCE_BIT    = 22;

    // True when the ID/EX instruction is a load that writes a real register.
    function automatic logic is_load(input logic rf_wb, input logic [1:0] wb_src,
                                     input logic [4:0] rd);
        return rf_wb && (wb_src == WB_MEM) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle of pipeline-register fields observed by the hazard controller and
// the stall/flush/forwarding controls it returns.
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_rf_wb;
    logic [1:0]       ex_wb_src;
    logic             ex_mc_op;
    logic             ex_redirect;
    logic [4:0]       mem_rd;
    logic             mem_rf_wb;
    logic [4:0]       wb_rd;
    logic             wb_rf_wb;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies register fields, consumes controls.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_rf_wb, ex_wb_src, ex_mc_op, ex_redirect,
               mem_rd, mem_rf_wb, wb_rd, wb_rf_wb,
        input  stall_if, stall_id, stall_ex, flush_id, flush_ex,
               fwd_a_sel, fwd_b_sel, mc_busy, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_rf_wb, ex_wb_src, ex_mc_op, ex_redirect,
               mem_rd, mem_rf_wb, wb_rd, wb_rf_wb,
        output stall_if, stall_id, stall_ex, flush_id, flush_ex,
               fwd_a_sel, fwd_b_sel, mc_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// Forwarding compare for one EX operand. EX/MEM wins over MEM/WB; x0 is
// hard-wired zero and never forwarded.
module ex_hazard_ctrl_fwd_unit
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_wb,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_wb,
    output fwd_sel_e   fwd_sel
);

    // Pick the youngest in-flight producer of ex_rs.
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_rf_wb && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_rf_wb && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing controller: load-use bubbles, redirect flushes,
// multi-cycle op stalls, operand forwarding and saturating perf counters.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input logic             clk,
    input logic             rst_n,
    ex_hazard_ctrl_if.slave bus
);

    if (MC_LATENCY < 2 || MC_LATENCY > 16) begin : g_bad_latency
        $error("ex_hazard_ctrl: MC_LATENCY must be within 2..16");
    end

    // The issue cycle in RUN counts as the first EX cycle, so the counter
    // covers the remaining MC_LATENCY-1 cycles ending at zero.
    localparam logic [MC_CNT_W-1:0] MC_INIT = MC_CNT_W'(MC_LATENCY - 2);

    state_e              state_q, state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

    logic     load_use;
    logic     redirect_evt;
    logic     stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_busy;
    fwd_sel_e fwd_a, fwd_b;

    ex_hazard_ctrl_fwd_unit u_fwd_a (
        .ex_rs     (bus.ex_rs1),
        .mem_rd    (bus.mem_rd),
        .mem_rf_wb (bus.mem_rf_wb),
        .wb_rd     (bus.wb_rd),
        .wb_rf_wb  (bus.wb_rf_wb),
        .fwd_sel   (fwd_a)
    );

    ex_hazard_ctrl_fwd_unit u_fwd_b (
        .ex_rs     (bus.ex_rs2),
        .mem_rd    (bus.mem_rd),
        .mem_rf_wb (bus.mem_rf_wb),
        .wb_rd     (bus.wb_rd),
        .wb_rf_wb  (bus.wb_rf_wb),
        .fwd_sel   (fwd_b)
    );

    assign load_use = is_load(bus.ex_rf_wb, bus.ex_wb_src, bus.ex_rd) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Next-state and control outputs; redirect beats multi-cycle issue beats load-use.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        mc_busy      = 1'b0;
        redirect_evt = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.ex_redirect) begin
                    // Younger instructions are squashed, so load-use is moot.
                    flush_id     = 1'b1;
                    flush_ex     = 1'b1;
                    redirect_evt = 1'b1;
                end else if (bus.ex_mc_op) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    mc_busy  = 1'b1;
                    state_d  = MC_BUSY;
                    mc_cnt_d = MC_INIT;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MC_BUSY: begin
                // EX inputs are frozen, so forwarding stays stable across the op.
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                mc_busy  = 1'b1;
                if (mc_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    mc_cnt_d = mc_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    // FSM state and multi-cycle down-counter; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops sample pre-edge values together.
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Saturating performance counters: stalled front-end cycles and redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_if  = stall_if;
    assign bus.stall_id  = stall_id;
    assign bus.stall_ex  = stall_ex;
    assign bus.flush_id  = flush_id;
    assign bus.flush_ex  = flush_ex;
    assign bus.fwd_a_sel = fwd_a;
    assign bus.fwd_b_sel = fwd_b;
    assign bus.mc_busy   = mc_busy;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl. Two instances share one stimulus:
// a 32-bit-counter instance and a 4-bit-counter instance for saturation.
module tb_ex_hazard_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_hazard_ctrl_if #(.CNT_W(32)) hif ();
    ex_hazard_ctrl_if #(.CNT_W(4))  hif4 ();

    ex_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    ex_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif4)
    );

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_rf_wb;
        logic [1:0] ex_wb_src;
        logic       ex_mc_op;
        logic       ex_redirect;
        logic [4:0] mem_rd;
        logic       mem_rf_wb;
        logic [4:0] wb_rd;
        logic       wb_rf_wb;
    } stim_t;

    // ctl = {stall_if, stall_id, stall_ex, flush_id, flush_ex}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        busy;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic [3:0]  s4;
        logic [3:0]  f4;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } exp_t;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11001;
    localparam logic [4:0] C_RD   = 5'b00011;
    localparam logic [4:0] C_MC   = 5'b11100;

    exp_t  sb[$];
    stim_t nx;
    logic  nx_rst;
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic drive(input stim_t s);
        hif.id_rs1       = s.id_rs1;      hif4.id_rs1      = s.id_rs1;
        hif.id_rs2       = s.id_rs2;      hif4.id_rs2      = s.id_rs2;
        hif.id_use_rs1   = s.id_use_rs1;  hif4.id_use_rs1  = s.id_use_rs1;
        hif.id_use_rs2   = s.id_use_rs2;  hif4.id_use_rs2  = s.id_use_rs2;
        hif.ex_rs1       = s.ex_rs1;      hif4.ex_rs1      = s.ex_rs1;
        hif.ex_rs2       = s.ex_rs2;      hif4.ex_rs2      = s.ex_rs2;
        hif.ex_rd        = s.ex_rd;       hif4.ex_rd       = s.ex_rd;
        hif.ex_rf_wb     = s.ex_rf_wb;    hif4.ex_rf_wb    = s.ex_rf_wb;
        hif.ex_wb_src    = s.ex_wb_src;   hif4.ex_wb_src   = s.ex_wb_src;
        hif.ex_mc_op     = s.ex_mc_op;    hif4.ex_mc_op    = s.ex_mc_op;
        hif.ex_redirect  = s.ex_redirect; hif4.ex_redirect = s.ex_redirect;
        hif.mem_rd       = s.mem_rd;      hif4.mem_rd      = s.mem_rd;
        hif.mem_rf_wb    = s.mem_rf_wb;   hif4.mem_rf_wb   = s.mem_rf_wb;
        hif.wb_rd        = s.wb_rd;       hif4.wb_rd       = s.wb_rd;
        hif.wb_rf_wb     = s.wb_rf_wb;    hif4.wb_rf_wb    = s.wb_rf_wb;
    endtask

    // Apply nx just after the rising edge and queue what the outputs must be
    // for this cycle; counters show the value accumulated before this cycle.
    task automatic step(input string name, input logic [4:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic busy, input int unsigned scnt,
                        input int unsigned fcnt, input bit drop_rst);
        exp_t e;
        @(posedge clk);
        #1;
        drive(nx);
        rst_n = nx_rst;
        if (drop_rst) begin
            #1;
            rst_n = 1'b0;
        end
        e.name     = name;
        e.exp.ctl  = ctl;
        e.exp.fa   = fa;
        e.exp.fb   = fb;
        e.exp.busy = busy;
        e.exp.scnt = scnt;
        e.exp.fcnt = fcnt;
        e.exp.s4   = (scnt > 15) ? 4'hf : scnt[3:0];
        e.exp.f4   = (fcnt > 15) ? 4'hf : fcnt[3:0];
        sb.push_back(e);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ctl  = {hif.stall_if, hif.stall_id, hif.stall_ex, hif.flush_id, hif.flush_ex};
        o.fa   = hif.fwd_a_sel;
        o.fb   = hif.fwd_b_sel;
        o.busy = hif.mc_busy;
        o.scnt = hif.stall_cnt;
        o.fcnt = hif.flush_cnt;
        o.s4   = hif4.stall_cnt;
        o.f4   = hif4.flush_cnt;
        return o;
    endfunction

    // Monitor: compare on the falling edge, away from the active edge.
    exp_t mon_e;
    obs_t mon_a;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            mon_a = sample();
            n_vec++;
            if (mon_a !== mon_e.exp) begin
                n_miss++;
                $display("FAIL %s: got ctl=%b fa=%b fb=%b busy=%b scnt=%0d fcnt=%0d s4=%0d f4=%0d, want ctl=%b fa=%b fb=%b busy=%b scnt=%0d fcnt=%0d s4=%0d f4=%0d",
                         mon_e.name, mon_a.ctl, mon_a.fa, mon_a.fb, mon_a.busy,
                         mon_a.scnt, mon_a.fcnt, mon_a.s4, mon_a.f4,
                         mon_e.exp.ctl, mon_e.exp.fa, mon_e.exp.fb, mon_e.exp.busy,
                         mon_e.exp.scnt, mon_e.exp.fcnt, mon_e.exp.s4, mon_e.exp.f4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nx     = '0;
        nx_rst = 1'b0;
        drive(nx);

        step("reset", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);
        nx_rst = 1'b1;

        // Forwarding priority and x0 handling.
        nx.mem_rd = 5; nx.mem_rf_wb = 1; nx.wb_rd = 5; nx.wb_rf_wb = 1;
        nx.ex_rs1 = 5; nx.ex_rs2 = 7;
        step("fwd_mem_prio", C_NONE, 2'b01, 2'b00, 1'b0, 0, 0, 1'b0);
        nx.mem_rd = 0;
        step("fwd_wb_mem_x0", C_NONE, 2'b10, 2'b00, 1'b0, 0, 0, 1'b0);
        nx.mem_rd = 5; nx.ex_rs1 = 7; nx.ex_rs2 = 5;
        step("fwd_b_mem", C_NONE, 2'b00, 2'b01, 1'b0, 0, 0, 1'b0);
        nx.mem_rd = 9; nx.mem_rf_wb = 0; nx.wb_rd = 7; nx.ex_rs1 = 9; nx.ex_rs2 = 7;
        step("fwd_mem_nowr", C_NONE, 2'b00, 2'b10, 1'b0, 0, 0, 1'b0);
        nx.mem_rd = 0; nx.mem_rf_wb = 1; nx.wb_rd = 0; nx.ex_rs1 = 0; nx.ex_rs2 = 0;
        step("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);

        // Load-use bubble.
        nx = '0;
        nx.ex_wb_src = 2'b01; nx.ex_rf_wb = 1; nx.ex_rd = 3; nx.id_rs2 = 3; nx.id_use_rs2 = 1;
        step("lu_rs2", C_LU, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);
        nx = '0;
        step("lu_release", C_NONE, 2'b00, 2'b00, 1'b0, 1, 0, 1'b0);
        nx.ex_wb_src = 2'b01; nx.ex_rf_wb = 1; nx.ex_rd = 0; nx.id_rs2 = 0; nx.id_use_rs2 = 1;
        step("lu_x0", C_NONE, 2'b00, 2'b00, 1'b0, 1, 0, 1'b0);
        nx.ex_rd = 3; nx.id_rs2 = 3; nx.id_use_rs2 = 0;
        step("lu_unused_src", C_NONE, 2'b00, 2'b00, 1'b0, 1, 0, 1'b0);
        nx.id_rs1 = 3; nx.id_use_rs1 = 1; nx.ex_wb_src = 2'b00;
        step("alu_no_lu", C_NONE, 2'b00, 2'b00, 1'b0, 1, 0, 1'b0);
        nx.ex_wb_src = 2'b01;
        step("lu_rs1", C_LU, 2'b00, 2'b00, 1'b0, 1, 0, 1'b0);
        nx = '0;
        step("lu_rs1_release", C_NONE, 2'b00, 2'b00, 1'b0, 2, 0, 1'b0);

        // Redirect coincident with load-use.
        nx.ex_wb_src = 2'b01; nx.ex_rf_wb = 1; nx.ex_rd = 3; nx.id_rs2 = 3; nx.id_use_rs2 = 1;
        nx.ex_redirect = 1;
        step("redir_over_lu", C_RD, 2'b00, 2'b00, 1'b0, 2, 0, 1'b0);
        nx = '0;
        step("redir_count", C_NONE, 2'b00, 2'b00, 1'b0, 2, 1, 1'b0);

        // Multi-cycle op at MC_LATENCY=4, redirect ignored while busy.
        nx_rst = 1'b0;
        step("rst_case4", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);
        nx_rst = 1'b1;
        nx.ex_mc_op = 1;
        step("mc_issue", C_MC, 2'b00, 2'b00, 1'b1, 0, 0, 1'b0);
        nx = '0; nx.ex_redirect = 1;
        step("mc_busy1_redir", C_MC, 2'b00, 2'b00, 1'b1, 1, 0, 1'b0);
        nx = '0;
        step("mc_busy2", C_MC, 2'b00, 2'b00, 1'b1, 2, 0, 1'b0);
        step("mc_busy3", C_MC, 2'b00, 2'b00, 1'b1, 3, 0, 1'b0);
        step("mc_done", C_NONE, 2'b00, 2'b00, 1'b0, 4, 0, 1'b0);
        nx.ex_mc_op = 1; nx.ex_redirect = 1;
        step("redir_over_mc", C_RD, 2'b00, 2'b00, 1'b0, 4, 0, 1'b0);
        nx = '0;
        step("redir_over_mc_cnt", C_NONE, 2'b00, 2'b00, 1'b0, 4, 1, 1'b0);

        // Asynchronous reset in the second busy cycle.
        nx.ex_mc_op = 1;
        step("mc5_issue", C_MC, 2'b00, 2'b00, 1'b1, 4, 1, 1'b0);
        nx = '0;
        step("mc5_async_rst", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0, 1'b1);
        nx_rst = 1'b0;
        step("mc5_in_rst", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);
        nx_rst = 1'b1;
        step("mc5_run_after", C_NONE, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0);

        // Saturation: 20 stall cycles and 17 redirects; 4-bit copy holds at 15.
        nx.ex_wb_src = 2'b01; nx.ex_rf_wb = 1; nx.ex_rd = 3; nx.id_rs2 = 3; nx.id_use_rs2 = 1;
        for (int i = 0; i < 20; i++) begin
            step("sat_stall", C_LU, 2'b00, 2'b00, 1'b0, i, 0, 1'b0);
        end
        nx = '0;
        step("sat_stall_hold", C_NONE, 2'b00, 2'b00, 1'b0, 20, 0, 1'b0);
        nx.ex_redirect = 1;
        for (int i = 0; i < 17; i++) begin
            step("sat_flush", C_RD, 2'b00, 2'b00, 1'b0, 20, i, 1'b0);
        end
        nx = '0;
        step("sat_final", C_NONE, 2'b00, 2'b00, 1'b0, 20, 17, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the execute stage. It detects load-use hazards, handles branch/jump redirects, and stalls the execute stage for multi-cycle ALU operations. It also generates the forwarding selects for the execute-stage A and B operands. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives their stall and flush inputs, and it keeps saturating performance counters.

Parameters:
MC_LATENCY, 4, total EX cycles of a multi-cycle op (mul/div); legal range 2..16
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  decode-stage source register 1
id_rs2  in  5  decode-stage source register 2
id_use_rs1  in  1  decode instruction reads rs1
id_use_rs2  in  1  decode instruction reads rs2
ex_rs1  in  5  rs1 of the instruction in EX
ex_rs2  in  5  rs2 of the instruction in EX
ex_rd  in  5  rd in ID/EX
ex_rf_wb  in  1  ID/EX register-file write enable
ex_wb_src  in  2  ID/EX writeback source; 00 ALU, 01 memory, 10 pc+4
ex_mc_op  in  1  the instruction in EX is multi-cycle
ex_redirect  in  1  branch_taken_ex OR pc_src from the 14-bit EX control word
mem_rd  in  5  EX/MEM rd
mem_rf_wb  in  1  EX/MEM register-file write enable
wb_rd  in  5  MEM/WB rd
wb_rf_wb  in  1  MEM/WB register-file write enable
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
flush_id  out  1  clear IF/ID to a NOP
flush_ex  out  1  insert a bubble into ID/EX (rf_wb=0, mem_we=0, branch=0)
fwd_a_sel  out  2  operand A select; 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  operand B select; same encoding as fwd_a_sel
mc_busy  out  1  a multi-cycle op is in progress
stall_cnt  out  CNT_W  count of cycles with stall_if=1
flush_cnt  out  CNT_W  count of redirect events

Behaviour:
- FSM states: RUN and MC_BUSY, plus a 4-bit down-counter mc_cnt.
- Reset (asynchronous, rst_n=0): state=RUN, mc_cnt=0, stall_cnt=0, flush_cnt=0.
  - All combinational outputs are then driven 0, because they derive from the cleared state and valid inputs.
  - Reset asserted mid-MC_BUSY aborts the op immediately.
- Forwarding is combinational and computed for each operand independently.
  - EX/MEM match (mem_rf_wb=1, mem_rd!=0, mem_rd==ex_rsX) gives 01.
  - Otherwise a MEM/WB match (wb_rf_wb=1, wb_rd!=0, wb_rd==ex_rsX) gives 10.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB; x0 is never forwarded.
- Load-use detection is combinational. load_use = ex_rf_wb & (ex_wb_src==01) & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN state, with priority from highest to lowest:
  1. ex_redirect=1: flush_id=1 and flush_ex=1, no stalls, flush_cnt+1, stay in RUN. Any load_use in the same cycle is ignored because the younger instruction is squashed.
  2. ex_mc_op=1: stall_if, stall_id and stall_ex=1. Next state is MC_BUSY with mc_cnt=MC_LATENCY-2.
  3. load_use=1: stall_if=1, stall_id=1, flush_ex=1 for exactly one cycle, then remain in RUN.
  4. Otherwise all control outputs are 0.
- MC_BUSY state:
  - mc_busy=1 and stall_if/id/ex=1, which holds EX inputs and forwarding stable.
  - Redirect and load_use are not evaluated.
  - mc_cnt decrements each cycle. When mc_cnt==0, the next state is RUN with stalls released that cycle (stalls still asserted in the final MC_BUSY cycle).
  - The total EX occupancy is MC_LATENCY cycles.
- Counters:
  - stall_cnt increments every cycle that stall_if=1.
  - flush_cnt increments on each redirect cycle.
  - Both saturate at all-ones with no wrap.
- MC_LATENCY<2 is illegal; the parameter is checked with an elaboration-time error.

Decomposition:
- Shared package holds:
  - wb_src encodings (WB_ALU=00, WB_MEM=01, WB_PC4=10)
  - forwarding select encodings (FWD_RF, FWD_MEM, FWD_WB)
  - FSM state typedef
  - control-word field offsets for the 23-bit decode and 14-bit EX control words
- One natural sub-module, fwd_unit: purely combinational forwarding compare, instantiated once per operand.
- Stall/flush FSM and counters remain in the top module.

Test Plan:
- Case 1, EX/MEM forwarding beats MEM/WB:
  - Stimulus: mem_rd=5, mem_rf_wb=1, wb_rd=5, wb_rf_wb=1, ex_rs1=5, ex_rs2=7.
  - Required response: fwd_a_sel=01, fwd_b_sel=00.
  - Repeat with mem_rd=0: fwd_a_sel=10.
- Case 2, single-cycle load-use bubble:
  - Stimulus: ex_wb_src=01, ex_rf_wb=1, ex_rd=3, id_rs2=3, id_use_rs2=1.
  - Required response: stall_if=stall_id=flush_ex=1 for exactly one cycle, stall_cnt=1.
  - Repeat with ex_rd=0: no stall.
- Case 3, redirect coincident with load_use:
  - Stimulus: ex_redirect=1 in the same cycle as load_use.
  - Required response: flush_id=flush_ex=1, stall_if=0, flush_cnt=1.
- Case 4, multi-cycle op at MC_LATENCY=4:
  - Stimulus: ex_mc_op pulse.
  - Required response: stall_if/id/ex and mc_busy high for exactly 4 cycles, RUN on cycle 5, stall_cnt=4.
  - An ex_redirect asserted during MC_BUSY is ignored.
- Case 5, reset mid-MC_BUSY:
  - Stimulus: drop rst_n asynchronously between clock edges in the 2nd busy cycle.
  - Required response: all outputs 0 immediately, counters 0, RUN after release.
- Case 6, counter saturation:
  - Stimulus: preload stall_cnt to 2^CNT_W-1 via a force, or use CNT_W=4 with 20 stall cycles.
  - Required response: the count holds at all-ones.
